// File: rtl/wrapping_fifo_sync_mc.sv
// Single-clock show-ahead FIFO with runtime wrap/block overflow policy, synchronous
// flush, programmable watermarks and sticky overflow / saturating drop statistics.
module wrapping_fifo_sync_mc #(
  parameter  int DEPTH     = 16,
  parameter  int WIDTH     = 8,
  parameter  int DROP_W    = 8,
  localparam int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_i,
  input  logic                 rd_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic [WIDTH-1:0]     data_o,
  input  logic                 mode_i,
  input  logic                 flush_i,
  input  logic [ADDR_SIZE:0]   af_thresh_i,
  input  logic [ADDR_SIZE:0]   ae_thresh_i,
  input  logic                 clr_stat_i,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [ADDR_SIZE:0]   count_o,
  output logic                 overflow_o,
  output logic [DROP_W-1:0]    drop_count_o,
  output logic [ADDR_SIZE:0]   read_ptr_f,
  output logic [ADDR_SIZE:0]   write_ptr_f
);

  localparam int PW = ADDR_SIZE + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              do_wr;
  logic              drop_evt;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == PW'(DEPTH));
  assign almost_full_o  = (count_q >= af_thresh_i);
  assign almost_empty_o = (count_q <= ae_thresh_i);
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign drop_count_o   = drop_q;
  assign read_ptr_f     = rptr_q;
  assign write_ptr_f    = wptr_q;
  assign data_o         = mem_q[rptr_q[ADDR_SIZE-1:0]];

  always_comb begin
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    do_wr    = 1'b0;
    drop_evt = 1'b0;
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (rd_i && !empty_o) rptr_d = rptr_q + 1'b1;
      if (wr_i) begin
        // A simultaneous read frees the slot, so a full FIFO still accepts the write.
        if (!full_o || rd_i) begin
          do_wr  = 1'b1;
          wptr_d = wptr_q + 1'b1;
        end else begin
          drop_evt = 1'b1;
          if (!mode_i) begin
            do_wr  = 1'b1;
            wptr_d = wptr_q + 1'b1;
            rptr_d = rptr_q + 1'b1;
          end
        end
      end
    end
    count_d = wptr_d - rptr_d;
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    // A drop in the same cycle as a clear is still recorded, starting from zero.
    if (drop_evt) begin
      ovf_d  = 1'b1;
      drop_d = clr_stat_i ? DROP_W'(1) : sat_inc(drop_q);
    end else if (clr_stat_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[ADDR_SIZE-1:0]] <= data_i;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= PW'(DEPTH));
  a_not_empty_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(empty_o && full_o));
  a_count_ptrs: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q == PW'(wptr_q - rptr_q));

endmodule

// File: tb/tb_wrapping_fifo_sync_mc.sv
// Randomised and directed bench for wrapping_fifo_sync_mc against a queue-based model.
module tb_wrapping_fifo_sync_mc;
  localparam int DEPTH  = 16;
  localparam int WIDTH  = 8;
  localparam int DROP_W = 2;
  localparam int PW     = 5;
  localparam int DCMAX  = 3;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             wr_i, rd_i, mode_i, flush_i, clr_stat_i;
  logic [WIDTH-1:0] data_i, data_o;
  logic [PW-1:0]    af_thresh_i, ae_thresh_i, count_o, read_ptr_f, write_ptr_f;
  logic             empty_o, full_o, almost_full_o, almost_empty_o, overflow_o;
  logic [DROP_W-1:0] drop_count_o;

  int nvec = 0;
  int nerr = 0;

  logic [WIDTH-1:0] mq[$];
  int  m_dc, m_wp, m_rp;
  bit  m_ovf;

  wrapping_fifo_sync_mc #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wr_i(wr_i), .rd_i(rd_i), .data_i(data_i),
    .data_o(data_o), .mode_i(mode_i), .flush_i(flush_i), .af_thresh_i(af_thresh_i),
    .ae_thresh_i(ae_thresh_i), .clr_stat_i(clr_stat_i), .empty_o(empty_o),
    .full_o(full_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o),
    .read_ptr_f(read_ptr_f), .write_ptr_f(write_ptr_f)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_dc = 0; m_wp = 0; m_rp = 0; m_ovf = 0;
  endtask

  task automatic model_update(input bit wr, input bit rd, input bit fl, input bit md,
                              input bit clr, input logic [WIDTH-1:0] d);
    bit drop = 0;
    if (fl) begin
      mq.delete();
      m_wp = 0; m_rp = 0;
    end else if (wr && !rd && mq.size() == DEPTH) begin
      drop = 1;
      if (!md) begin
        void'(mq.pop_front());
        mq.push_back(d);
        m_wp = (m_wp + 1) % 32;
        m_rp = (m_rp + 1) % 32;
      end
    end else begin
      if (rd && mq.size() > 0) begin
        void'(mq.pop_front());
        m_rp = (m_rp + 1) % 32;
      end
      if (wr) begin
        mq.push_back(d);
        m_wp = (m_wp + 1) % 32;
      end
    end
    if (drop) begin
      m_ovf = 1;
      m_dc  = clr ? 1 : ((m_dc + 1 > DCMAX) ? DCMAX : m_dc + 1);
    end else if (clr) begin
      m_ovf = 0;
      m_dc  = 0;
    end
  endtask

  // Drive one cycle: inputs set at negedge, model advanced at posedge, return at next negedge.
  task automatic step(input bit wr, input bit rd, input bit fl, input bit md,
                      input bit clr, input logic [WIDTH-1:0] d);
    wr_i = wr; rd_i = rd; flush_i = fl; mode_i = md; clr_stat_i = clr; data_i = d;
    @(posedge clk);
    model_update(wr, rd, fl, md, clr, d);
    @(negedge clk);
    wr_i = 0; rd_i = 0; flush_i = 0; clr_stat_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    model_reset();
    repeat (2) @(negedge clk);
    nvec++; if (count_o !== 5'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count_o); end
    nvec++; if (empty_o !== 1'b1) begin nerr++; $display("FAIL reset_empty got %b want 1", empty_o); end
    nvec++; if (full_o !== 1'b0) begin nerr++; $display("FAIL reset_full got %b want 0", full_o); end
    nvec++; if (almost_empty_o !== 1'b1) begin nerr++; $display("FAIL reset_ae got %b want 1", almost_empty_o); end
    nvec++; if (overflow_o !== 1'b0 || drop_count_o !== 2'd0) begin nerr++;
      $display("FAIL reset_stats got ovf=%b dc=%0d want 0/0", overflow_o, drop_count_o); end
    nvec++; if (read_ptr_f !== 5'd0 || write_ptr_f !== 5'd0) begin nerr++;
      $display("FAIL reset_ptrs got rp=%0d wp=%0d want 0/0", read_ptr_f, write_ptr_f); end
    rst_ni = 1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    step(0, 0, 1, 0, 1, 8'h00);
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 0, 0, 8'(i));
    nvec++; if (full_o !== 1'b1) begin nerr++; $display("FAIL fd_full got %b want 1", full_o); end
    for (int i = 1; i <= DEPTH; i++) begin
      nvec++; if (data_o !== 8'(i)) begin nerr++; $display("FAIL fd_data[%0d] got %02h want %02h", i, data_o, 8'(i)); end
      step(0, 1, 0, 0, 0, 8'h00);
    end
    nvec++; if (empty_o !== 1'b1) begin nerr++; $display("FAIL fd_empty got %b want 1", empty_o); end
    nvec++; if (drop_count_o !== 2'd0) begin nerr++; $display("FAIL fd_drops got %0d want 0", drop_count_o); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 8'(i));
    step(1, 0, 0, 0, 0, 8'h10);
    step(1, 0, 0, 0, 0, 8'h11);
    nvec++; if (count_o !== 5'd16) begin nerr++; $display("FAIL wrap_count got %0d want 16", count_o); end
    nvec++; if (data_o !== 8'h02) begin nerr++; $display("FAIL wrap_head got %02h want 02", data_o); end
    nvec++; if (drop_count_o !== 2'd2 || overflow_o !== 1'b1) begin nerr++;
      $display("FAIL wrap_stats got dc=%0d ovf=%b want 2/1", drop_count_o, overflow_o); end
    nvec++; if (read_ptr_f !== 5'd2 || write_ptr_f !== 5'd18) begin nerr++;
      $display("FAIL wrap_ptrs got rp=%0d wp=%0d want 2/18", read_ptr_f, write_ptr_f); end
  endtask

  task automatic test_block();
    step(0, 0, 1, 1, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 1, 0, 8'(i));
    step(1, 0, 0, 1, 0, 8'hAA);
    nvec++; if (count_o !== 5'd16) begin nerr++; $display("FAIL blk_count got %0d want 16", count_o); end
    nvec++; if (data_o !== 8'h00) begin nerr++; $display("FAIL blk_head got %02h want 00", data_o); end
    nvec++; if (write_ptr_f !== 5'd16) begin nerr++; $display("FAIL blk_wp got %0d want 16", write_ptr_f); end
    nvec++; if (drop_count_o !== 2'd1 || overflow_o !== 1'b1) begin nerr++;
      $display("FAIL blk_stats got dc=%0d ovf=%b want 1/1", drop_count_o, overflow_o); end
    for (int i = 0; i < DEPTH; i++) begin
      nvec++; if (data_o !== 8'(i)) begin nerr++; $display("FAIL blk_data[%0d] got %02h want %02h", i, data_o, 8'(i)); end
      step(0, 1, 0, 1, 0, 8'h00);
    end
    nvec++; if (empty_o !== 1'b1) begin nerr++; $display("FAIL blk_empty got %b want 1", empty_o); end
  endtask

  task automatic test_full_rw();
    for (int md = 0; md < 2; md++) begin
      step(0, 0, 1, md[0], 1, 8'h00);
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, md[0], 0, 8'(8'h20 + i));
      step(1, 1, 0, md[0], 0, 8'h55);
      nvec++; if (count_o !== 5'd16) begin nerr++; $display("FAIL frw%0d_count got %0d want 16", md, count_o); end
      nvec++; if (data_o !== 8'h21) begin nerr++; $display("FAIL frw%0d_head got %02h want 21", md, data_o); end
      nvec++; if (drop_count_o !== 2'd0 || overflow_o !== 1'b0) begin nerr++;
        $display("FAIL frw%0d_stats got dc=%0d ovf=%b want 0/0", md, drop_count_o, overflow_o); end
    end
  endtask

  task automatic test_watermarks();
    af_thresh_i = 5'd12; ae_thresh_i = 5'd3;
    step(0, 0, 1, 1, 1, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 1, 0, 8'(i));
      nvec++; if (almost_full_o !== (i >= 12)) begin nerr++;
        $display("FAIL wm_af@%0d got %b want %b", i, almost_full_o, (i >= 12)); end
    end
    for (int c = 11; c >= 3; c--) begin
      step(0, 1, 0, 1, 0, 8'h00);
      nvec++; if (almost_empty_o !== (c <= 3)) begin nerr++;
        $display("FAIL wm_ae@%0d got %b want %b", c, almost_empty_o, (c <= 3)); end
    end
    for (int i = 0; i < 14; i++) step(1, 0, 0, 1, 0, 8'hC0);
    step(1, 1, 1, 1, 0, 8'hEE);
    nvec++; if (count_o !== 5'd0 || empty_o !== 1'b1) begin nerr++;
      $display("FAIL wm_flush got count=%0d empty=%b want 0/1", count_o, empty_o); end
    nvec++; if (drop_count_o !== 2'd1 || overflow_o !== 1'b1) begin nerr++;
      $display("FAIL wm_retain got dc=%0d ovf=%b want 1/1", drop_count_o, overflow_o); end
    af_thresh_i = 5'd0; ae_thresh_i = 5'd16;
    #1;
    nvec++; if (almost_full_o !== 1'b1) begin nerr++; $display("FAIL wm_af0 got %b want 1", almost_full_o); end
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 1, 0, 8'(i));
    nvec++; if (almost_empty_o !== 1'b1) begin nerr++; $display("FAIL wm_ae16 got %b want 1", almost_empty_o); end
    af_thresh_i = 5'd12; ae_thresh_i = 5'd3;
  endtask

  task automatic test_saturation();
    step(0, 0, 1, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 8'(i));
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 0, 0, 0, 8'(8'h40 + k));
      nvec++; if (drop_count_o !== 2'((k > DCMAX) ? DCMAX : k)) begin nerr++;
        $display("FAIL sat_dc@%0d got %0d want %0d", k, drop_count_o, (k > DCMAX) ? DCMAX : k); end
    end
    step(0, 0, 0, 0, 1, 8'h00);
    nvec++; if (drop_count_o !== 2'd0 || overflow_o !== 1'b0) begin nerr++;
      $display("FAIL sat_clr got dc=%0d ovf=%b want 0/0", drop_count_o, overflow_o); end
    step(1, 0, 0, 0, 0, 8'h50);
    step(1, 0, 0, 0, 0, 8'h51);
    step(1, 0, 0, 0, 1, 8'h52);
    nvec++; if (drop_count_o !== 2'd1 || overflow_o !== 1'b1) begin nerr++;
      $display("FAIL sat_clr_drop got dc=%0d ovf=%b want 1/1", drop_count_o, overflow_o); end
    nvec++; if (data_o !== 8'h08) begin nerr++; $display("FAIL sat_head got %02h want 08", data_o); end
  endtask

  task automatic test_random();
    step(0, 0, 1, 0, 1, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        af_thresh_i = 5'($urandom_range(0, 17));
        ae_thresh_i = 5'($urandom_range(0, 17));
      end
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0,
           1'($urandom), $urandom_range(0, 29) == 0, 8'($urandom));
      nvec++; if (count_o !== 5'(mq.size())) begin nerr++;
        $display("FAIL rnd_count@%0d got %0d want %0d", n, count_o, mq.size()); end
      nvec++; if (empty_o !== (mq.size() == 0) || full_o !== (mq.size() == DEPTH)) begin nerr++;
        $display("FAIL rnd_flags@%0d got e=%b f=%b want size %0d", n, empty_o, full_o, mq.size()); end
      nvec++; if (almost_full_o !== (mq.size() >= int'(af_thresh_i)) ||
                  almost_empty_o !== (mq.size() <= int'(ae_thresh_i))) begin nerr++;
        $display("FAIL rnd_wm@%0d got af=%b ae=%b size %0d", n, almost_full_o, almost_empty_o, mq.size()); end
      nvec++; if (overflow_o !== m_ovf || drop_count_o !== 2'(m_dc)) begin nerr++;
        $display("FAIL rnd_stats@%0d got ovf=%b dc=%0d want %b/%0d", n, overflow_o, drop_count_o, m_ovf, m_dc); end
      nvec++; if (write_ptr_f !== 5'(m_wp) || read_ptr_f !== 5'(m_rp)) begin nerr++;
        $display("FAIL rnd_ptrs@%0d got wp=%0d rp=%0d want %0d/%0d", n, write_ptr_f, read_ptr_f, m_wp, m_rp); end
      if (mq.size() > 0) begin
        nvec++; if (data_o !== mq[0]) begin nerr++;
          $display("FAIL rnd_data@%0d got %02h want %02h", n, data_o, mq[0]); end
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 0, 0, 0, 8'(i));
    #2;
    rst_ni = 0;
    #1;
    model_reset();
    nvec++; if (count_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin nerr++;
      $display("FAIL arst_flags got count=%0d e=%b f=%b want 0/1/0", count_o, empty_o, full_o); end
    nvec++; if (overflow_o !== 1'b0 || drop_count_o !== 2'd0) begin nerr++;
      $display("FAIL arst_stats got ovf=%b dc=%0d want 0/0", overflow_o, drop_count_o); end
    nvec++; if (read_ptr_f !== 5'd0 || write_ptr_f !== 5'd0) begin nerr++;
      $display("FAIL arst_ptrs got rp=%0d wp=%0d want 0/0", read_ptr_f, write_ptr_f); end
    @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 0; wr_i = 0; rd_i = 0; mode_i = 0; flush_i = 0; clr_stat_i = 0;
    data_i = '0; af_thresh_i = 5'd12; ae_thresh_i = 5'd3;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_block();
    test_full_rw();
    test_watermarks();
    test_saturation();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wrapping_fifo_sync_mc.md
Name: wrapping_fifo_sync_mc

Overview:
Single-clock parametrised FIFO for the UART-lite datapath (RX character buffer, TX staging). It is the successor to the fixed wrapping FIFO and adds:
- runtime-selectable overflow policy: wrap (drop oldest) or block (drop incoming);
- synchronous flush;
- programmable almost-full/almost-empty watermarks;
- sticky overflow flag and saturating drop counter for the status register block.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
WIDTH, 8, data word width in bits
DROP_W, 8, width of saturating drop counter
ADDR_SIZE, $clog2(DEPTH), localparam; pointers and count are ADDR_SIZE+1 bits

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  asynchronous active-low reset
wr_i  in  1  write strobe, data_i captured when accepted
rd_i  in  1  read strobe, pops head entry
data_i  in  WIDTH  write data
data_o  out  WIDTH  head entry (show-ahead); don't-care while empty_o=1
mode_i  in  1  0 = wrap (overwrite oldest when full), 1 = block (discard incoming when full)
flush_i  in  1  synchronous flush, empties FIFO
af_thresh_i  in  ADDR_SIZE+1  almost-full threshold
ae_thresh_i  in  ADDR_SIZE+1  almost-empty threshold
clr_stat_i  in  1  clears overflow_o and drop_count_o
empty_o  out  1  count_o == 0
full_o  out  1  count_o == DEPTH
almost_full_o  out  1  count_o >= af_thresh_i
almost_empty_o  out  1  count_o <= ae_thresh_i
count_o  out  ADDR_SIZE+1  number of stored entries, 0..DEPTH
overflow_o  out  1  sticky: a drop has occurred since last clear/reset
drop_count_o  out  DROP_W  saturating count of dropped words
read_ptr_f  out  ADDR_SIZE+1  read pointer, for formal
write_ptr_f  out  ADDR_SIZE+1  write pointer, for formal

Behaviour:
- Reset (rst_ni=0, async):
  - pointers, count_o, overflow_o and drop_count_o = 0.
  - Resulting outputs: empty_o=1, full_o=0, almost_empty_o=1 iff ae_thresh_i>=0 (always).
  - Storage is not reset.
- Pointers: ADDR_SIZE+1 bits, wrap modulo 2^(ADDR_SIZE+1). Memory is indexed by the low ADDR_SIZE bits.
  - count_o = write_ptr - read_ptr, registered.
  - empty_o, full_o and watermarks are combinational from the registered count_o.
- data_o = mem[read_ptr]: zero-latency show-ahead. A word written in cycle N is visible on data_o in cycle N+1 if the FIFO was empty.
- Per-cycle priority (highest first):
  1. flush_i=1: read_ptr<=0, write_ptr<=0, count<=0. wr_i and rd_i are ignored. Stats are unchanged unless clr_stat_i is also asserted.
  2. Normal operation:
     - rd_i && !empty_o: read_ptr+1.
     - rd_i && empty_o: ignored, no error.
     - wr_i && !full_o: mem[write_ptr]<=data_i, write_ptr+1.
     - wr_i && full_o && rd_i: normal write plus read; count stays DEPTH; no drop.
     - wr_i && full_o && !rd_i, mode_i=0 (wrap): write stored, write_ptr+1, read_ptr+1 (oldest lost); count stays DEPTH; drop event.
     - wr_i && full_o && !rd_i, mode_i=1 (block): write discarded; pointers unchanged; drop event.
     - wr_i && rd_i while empty: write accepted, read ignored; count becomes 1.
- Drop event: overflow_o<=1; drop_count_o<=drop_count_o+1, saturating at 2^DROP_W-1.
- clr_stat_i=1: overflow_o<=0 and drop_count_o<=0. If a drop event occurs in the same cycle, the drop wins: overflow_o<=1, drop_count_o<=1.
- mode_i is sampled every cycle and may change at any time. Its effect applies only to the current cycle's full-write case.
- Watermarks are pure comparisons on unsigned values.
  - af_thresh_i=0 makes almost_full_o always 1.
  - ae_thresh_i>=DEPTH makes almost_empty_o always 1.
- Invariants, every cycle after reset:
  - count_o <= DEPTH.
  - !(empty_o && full_o).
  - write_ptr_f == number of accepted writes (mod 2^(ADDR_SIZE+1)).
  - read_ptr_f == reads + wrap-mode drops (mod 2^(ADDR_SIZE+1)).

Test Plan:
- Reset, write 0x01..0x10 (DEPTH=16), read 16 -> data_o sequence 0x01..0x10; full_o=1 after 16th write; empty_o=1 after last read; drop_count_o=0.
- Wrap mode: fill 0x00..0x0F, write 0x10, 0x11 without reads -> count_o=16; data_o=0x02; drop_count_o=2; overflow_o=1.
- Block mode: fill 0x00..0x0F, write 0xAA -> count_o=16; data_o=0x00; last read returns 0x0F; drop_count_o=1; write_ptr_f unchanged.
- Full with wr_i and rd_i in the same cycle, both modes -> count_o stays 16; no drop; head advances by one.
- af_thresh_i=12, ae_thresh_i=3: write 12 -> almost_full_o rises on count 12; read to 3 -> almost_empty_o rises; flush with wr_i=1 -> count_o=0; write ignored; stats retained.
- DROP_W=2: five wrap-mode drops -> drop_count_o saturates at 3. clr_stat_i coincident with a drop -> drop_count_o=1. Mid-stream rst_ni low -> all outputs return to reset values immediately.
